// File: rtl/fib_inst_gen_if.sv
// Instruction-stream bus between the Fibonacci program source and its consumer.
// Valid/ready: a word is taken on a rising edge where inst_valid=1 and stall=0;
// while stall=1 the producer holds inst/inst_valid unchanged.
interface fib_inst_gen_if;
  logic        start;
  logic        stall;
  logic [31:0] inst;
  logic        inst_valid;
  logic        busy;
  logic        done;
  logic [7:0]  issued;
  logic [2:0]  dbg_state;

  modport master (
    input  start,
    input  stall,
    output inst,
    output inst_valid,
    output busy,
    output done,
    output issued,
    output dbg_state
  );

  modport slave (
    output start,
    output stall,
    input  inst,
    input  inst_valid,
    input  busy,
    input  done,
    input  issued,
    input  dbg_state
  );
endinterface

// File: rtl/fib_inst_gen.sv
// Emits a fixed MIPS Fibonacci program (two addi, then N_ITER alternating add)
// one instruction per accepted cycle; every output is registered.
module fib_inst_gen #(
  parameter int N_ITER = 10
) (
  input  logic          clk,
  input  logic          reset,
  fib_inst_gen_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT1 = 3'd1,
    S_INIT2 = 3'd2,
    S_LOOP  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [31:0] NOP_W   = 32'h0000_0000;
  localparam logic [31:0] INIT1_W = 32'h2001_0001;  // addi $1,$0,1
  localparam logic [31:0] INIT2_W = 32'h2002_0001;  // addi $2,$0,1
  localparam logic [31:0] ADD1_W  = 32'h0022_0820;  // add  $1,$1,$2
  localparam logic [31:0] ADD2_W  = 32'h0022_1020;  // add  $2,$1,$2
  // Only consulted when N_ITER > 0, so the wrap at N_ITER = 0 is harmless.
  localparam logic [7:0]  LAST_IDX = 8'(N_ITER - 1);

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  issued_q, issued_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        accept;

  assign accept = valid_q && !bus.stall;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    issued_d = issued_q;
    if (accept) issued_d = issued_q + 8'd1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d  = S_INIT1;
          idx_d    = 8'd0;
          issued_d = 8'd0;
        end
      end
      S_INIT1: if (accept) state_d = S_INIT2;
      S_INIT2: begin
        if (accept) begin
          idx_d   = 8'd0;
          state_d = (N_ITER == 0) ? S_DONE : S_LOOP;
        end
      end
      S_LOOP: begin
        if (accept) begin
          if (idx_q == LAST_IDX) state_d = S_DONE;
          else                   idx_d   = idx_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    inst_d  = NOP_W;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      S_INIT1: begin inst_d = INIT1_W; valid_d = 1'b1; busy_d = 1'b1; end
      S_INIT2: begin inst_d = INIT2_W; valid_d = 1'b1; busy_d = 1'b1; end
      S_LOOP: begin
        inst_d  = idx_d[0] ? ADD2_W : ADD1_W;
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= 8'd0;
      issued_q <= 8'd0;
      inst_q   <= NOP_W;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      issued_q <= issued_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.inst       = inst_q;
  assign bus.inst_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.issued     = issued_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: doc/fib_inst_gen.md
Name: fib_inst_gen

Overview:
- Instruction-stream source for the single-cycle `cpu`; it is the producer that drives the cpu's instruction input.
- On `start`, it emits a fixed MIPS Fibonacci program one instruction per accepted cycle: two `addi` initialisations, then `N_ITER` alternating `add` instructions.
- Replaces hand-sequenced bench stimulus. It is also the front end for a later instruction-ROM/PC block.

Parameters:
- N_ITER, 10, number of Fibonacci `add` instructions after initialisation; legal range 0..253.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  pulse; begins a program run when sampled in IDLE or DONE
- stall  input  1  consumer not ready; holds the current instruction and state
- inst  output  32  instruction word to the cpu
- inst_valid  output  1  `inst` is a program instruction this cycle
- busy  output  1  run in progress (states INIT1, INIT2, LOOP)
- done  output  1  run complete; sticky until next start or reset
- issued  output  8  count of instructions accepted in the current run

Behaviour:
- Reset is synchronous and active-high. The clock is `clk`, the reset is `reset`.
- Reset values: state IDLE, `inst` = 0x00000000 (NOP), `inst_valid` = 0, `busy` = 0, `done` = 0, `issued` = 0, loop index = 0.
- All outputs are registered.
- States: IDLE, INIT1, INIT2, LOOP, DONE.
- Instruction encodings:
  - INIT1: `addi $1,$0,1` = 0x20010001
  - INIT2: `addi $2,$0,1` = 0x20020001
  - LOOP, even index: `add $1,$1,$2` = 0x00220820
  - LOOP, odd index: `add $2,$1,$2` = 0x00221020
- Accept rule: an instruction is accepted on a rising edge where `inst_valid` = 1 and `stall` = 0. On acceptance, `issued` increments by 1 and the state/index advances.
- While `stall` = 1: `inst`, `inst_valid`, state, index and `issued` all hold.
- Transitions:
  - IDLE --start--> INIT1. `inst_valid` = 1 in the cycle after start is sampled; one-cycle latency.
  - INIT1 --accept--> INIT2.
  - INIT2 --accept--> LOOP (index = 0). If N_ITER = 0, INIT2 goes directly to DONE.
  - LOOP --accept--> LOOP with index+1, or DONE when the accepted index = N_ITER-1.
  - DONE --start--> INIT1. `issued` clears to 0, `done` clears, and INIT1 is presented next cycle.
- Outside INIT1/INIT2/LOOP: `inst` = 0x00000000 and `inst_valid` = 0.
- `busy` = 1 exactly in INIT1, INIT2 and LOOP. `done` = 1 exactly in DONE.
- Total instructions per run = N_ITER+2. `issued` never wraps within the legal parameter range.
- `start` while busy is ignored; it neither restarts nor queues.
- `start` and `stall` together in IDLE: the start is taken. The stall only affects the first valid cycle.
- Reset asserted mid-run (any state, including while stalled): on the next edge, return to the reset values. Reset has priority over `start` and `stall`.
- `stall` has no effect in IDLE or DONE.

Test Plan:
- Reset, then `start` pulse with `stall` = 0, N_ITER = 10 → exactly 12 valid cycles, in order:
  - 0x20010001, 0x20020001
  - then 0x00220820 / 0x00221020 alternating, five of each, starting with 0x00220820
  - `done` = 1 on the 13th cycle, `issued` = 12, `busy` = 0.
- Same run feeding `cpu` (or a register-file reference model) → final $1 = 89, $2 = 144.
- Hold `stall` = 1 for 3 cycles during LOOP index 4 → `inst` stays 0x00220820 for 4 cycles and `issued` is frozen. The total sequence is identical to the unstalled run.
- `start` pulsed during LOOP → no effect; the run completes with `issued` = 12. A second `start` in DONE → run restarts, `issued` = 0 then counts to 12 again.
- `reset` asserted for 1 cycle while in LOOP at index 6 → next cycle `inst` = 0, `inst_valid` = 0, `busy` = 0, `done` = 0, `issued` = 0. A following `start` produces the full sequence from 0x20010001.
- N_ITER = 0 → exactly two valid instructions (0x20010001, 0x20020001), then DONE with `issued` = 2.
